ctrl_sequencer: RTL and testbench

Instruction fetch/decode/sequencing controller that sits directly upstream of the ALU stage. Each instruction is a 16-bit word fetched over a request/acknowledge memory handshake. The block decodes it into the ALU control fields (ALUK, SR2select, REGISTER1, REGISTER2, DATA, ADDRESS, GATEALU). It then sequences a writeback strobe so the register bank captures ANSWER. One instruction completes per FETCH→DECODE→EXECUTE→WRITEBACK pass.

---
 rtl/mcu_pkg.sv | 37 +++
 rtl/instr_decode.sv | 49 ++++
 rtl/ctrl_sequencer.sv | 106 ++++++++++
 tb/tb_ctrl_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, ALU control
// encodings, sequencer state encoding and the decoded-field bundle.
package mcu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_ADDA = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] ALUK_ADD = 2'b11;

  localparam logic [1:0] SR2SEL_REG  = 2'b00;
  localparam logic [1:0] SR2SEL_DATA = 2'b01;
  localparam logic [1:0] SR2SEL_ADDR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

  // Everything the ALU stage and register bank need from one instruction
  typedef struct packed {
    logic [1:0] aluk;
    logic [1:0] sr2select;
    logic [2:0] register1;
    logic [2:0] register2;
    logic [2:0] dr;
    logic [7:0] data;
    logic [6:0] address;
  } fields_t;

endpackage

// File: rtl/instr_decode.sv
// Purely combinational instruction decoder: splits a 16-bit instruction word
// into ALU control fields and classifies it. Unused operands come out as 0.
module instr_decode
  import mcu_pkg::*;
(
  input  logic [15:0] ir,
  output fields_t     fields,
  output logic        is_alu,
  output logic        is_halt,
  output logic        is_illegal
);

  always_comb begin
    fields     = '0;
    is_alu     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (ir[15:12])
      OP_NOP: ;
      OP_ADD: begin
        is_alu           = 1'b1;
        fields.aluk      = ALUK_ADD;
        fields.sr2select = SR2SEL_REG;
        fields.dr        = ir[11:9];
        fields.register1 = ir[8:6];
        fields.register2 = ir[2:0];
      end
      OP_ADDI: begin
        is_alu           = 1'b1;
        fields.aluk      = ALUK_ADD;
        fields.sr2select = SR2SEL_DATA;
        fields.dr        = ir[11:9];
        fields.register1 = ir[11:9];
        fields.data      = ir[7:0];
      end
      OP_ADDA: begin
        is_alu           = 1'b1;
        fields.aluk      = ALUK_ADD;
        fields.sr2select = SR2SEL_ADDR;
        fields.dr        = ir[11:9];
        fields.register1 = ir[11:9];
        fields.address   = ir[6:0];
      end
      OP_HALT: is_halt = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute/writeback sequencer feeding the ALU stage. Fetches one
// 16-bit instruction per pass over a req/ack handshake and strobes writeback.
module ctrl_sequencer
  import mcu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
)
(
  input  logic            CLK,
  input  logic            RST,
  input  logic            RUN,
  output logic            IMEM_REQ,
  output logic [PC_W-1:0] IMEM_ADDR,
  input  logic            IMEM_ACK,
  input  logic [15:0]     IMEM_RDATA,
  output logic [1:0]      ALUK,
  output logic [1:0]      SR2select,
  output logic [2:0]      REGISTER1,
  output logic [2:0]      REGISTER2,
  output logic [7:0]      DATA,
  output logic [6:0]      ADDRESS,
  output logic            GATEALU,
  output logic            LDREG,
  output logic [2:0]      DR,
  output logic            HALTED,
  output logic            ILLEGAL
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  fields_t         dec_fields, fld;
  logic            is_alu, is_halt, is_illegal;

  instr_decode u_decode (
    .ir         (ir),
    .fields     (dec_fields),
    .is_alu     (is_alu),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // IR and PC only move on the accepted fetch; ACK elsewhere is ignored
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc <= RESET_PC;
      ir <= '0;
    end else if (state == ST_FETCH && IMEM_ACK) begin
      ir <= IMEM_RDATA;
      pc <= pc + PC_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                    fld <= '0;
    else if (state == ST_DECODE) fld <= dec_fields;
  end

  always_comb begin
    state_nxt = state;
    IMEM_REQ  = 1'b0;
    GATEALU   = 1'b0;
    LDREG     = 1'b0;
    HALTED    = 1'b0;
    ILLEGAL   = 1'b0;
    case (state)
      ST_IDLE: if (RUN) state_nxt = ST_FETCH;
      ST_FETCH: begin
        IMEM_REQ = 1'b1;
        if (IMEM_ACK) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        ILLEGAL = is_illegal;
        if (is_alu)       state_nxt = ST_EXECUTE;
        else if (is_halt) state_nxt = ST_HALT;
        else              state_nxt = ST_FETCH;
      end
      ST_EXECUTE: begin
        GATEALU   = 1'b1;
        state_nxt = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        LDREG     = 1'b1;
        state_nxt = RUN ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: HALTED = 1'b1;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign IMEM_ADDR = pc;
  assign ALUK      = fld.aluk;
  assign SR2select = fld.sr2select;
  assign REGISTER1 = fld.register1;
  assign REGISTER2 = fld.register2;
  assign DATA      = fld.data;
  assign ADDRESS   = fld.address;
  assign DR        = fld.dr;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: a per-cycle expected trace is built
// from instruction-level rules, then replayed against the DUT and compared.
module tb_ctrl_sequencer;

  localparam logic [7:0] RST_PC = 8'hFF;

  localparam int T_RESET = 1, T_FIRST = 2, T_ADD_EXEC = 3, T_ADD_WB = 4,
                 T_NEXT = 5, T_ADDI = 6, T_ADDA = 7, T_ILL = 8, T_HALT = 9;

  logic       CLK = 1'b0;
  logic       RST, RUN, IMEM_REQ, IMEM_ACK, GATEALU, LDREG, HALTED, ILLEGAL;
  logic [7:0] IMEM_ADDR, DATA;
  logic [15:0] IMEM_RDATA;
  logic [1:0] ALUK, SR2select;
  logic [2:0] REGISTER1, REGISTER2, DR;
  logic [6:0] ADDRESS;

  always #5 CLK = ~CLK;

  ctrl_sequencer #(.PC_W(8), .RESET_PC(RST_PC)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_ACK(IMEM_ACK), .IMEM_RDATA(IMEM_RDATA),
    .ALUK(ALUK), .SR2select(SR2select),
    .REGISTER1(REGISTER1), .REGISTER2(REGISTER2),
    .DATA(DATA), .ADDRESS(ADDRESS),
    .GATEALU(GATEALU), .LDREG(LDREG), .DR(DR),
    .HALTED(HALTED), .ILLEGAL(ILLEGAL)
  );

  typedef struct packed {
    logic [1:0] aluk;
    logic [1:0] sr2;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [2:0] dr;
    logic [7:0] data;
    logic [6:0] address;
  } fld_t;

  typedef struct packed {
    logic       req;
    logic [7:0] addr;
    logic       gate;
    logic       ldreg;
    logic       halted;
    logic       illegal;
    fld_t       f;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        run;
    logic        ack;
    logic [15:0] rdata;
    exp_t        e;
    int          tag;
    bit          mid_rst;
  } cyc_t;

  cyc_t trace[$];
  logic [7:0] m_pc;
  fld_t       m_f;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // What the register bank sees after an instruction has been decoded
  function automatic fld_t ref_fields(input logic [15:0] ins);
    fld_t f;
    f = '0;
    if (ins[15:12] == 4'h1) begin
      f.aluk = 2'b11; f.sr2 = 2'b00;
      f.dr = ins[11:9]; f.r1 = ins[8:6]; f.r2 = ins[2:0];
    end else if (ins[15:12] == 4'h2) begin
      f.aluk = 2'b11; f.sr2 = 2'b01;
      f.dr = ins[11:9]; f.r1 = ins[11:9]; f.data = ins[7:0];
    end else if (ins[15:12] == 4'h3) begin
      f.aluk = 2'b11; f.sr2 = 2'b10;
      f.dr = ins[11:9]; f.r1 = ins[11:9]; f.address = ins[6:0];
    end
    return f;
  endfunction

  function automatic exp_t quiet();
    exp_t e;
    e   = '0;
    e.f = m_f;
    return e;
  endfunction

  task automatic push(input logic rst, input logic run, input logic ack,
                      input logic [15:0] rdata, input exp_t e, input int tag,
                      input bit mid);
    cyc_t c;
    c.rst = rst; c.run = run; c.ack = ack; c.rdata = rdata;
    c.e = e; c.tag = tag; c.mid_rst = mid;
    trace.push_back(c);
  endtask

  task automatic gen_reset(input int n);
    m_pc = RST_PC;
    m_f  = '0;
    for (int i = 0; i < n; i++)
      push(1'b1, 1'b0, rbit(), 16'($urandom), '0, (i == 0) ? T_RESET : 0, 1'b0);
  endtask

  task automatic gen_idle(input int n);
    for (int i = 0; i < n; i++)
      push(1'b0, 1'b0, rbit(), 16'($urandom), quiet(), 0, 1'b0);
    push(1'b0, 1'b1, rbit(), 16'($urandom), quiet(), 0, 1'b0);
  endtask

  task automatic gen_instr(input logic [15:0] ins, input int w, input logic wb_run,
                           input int tf, input int td, input int te, input int tw,
                           input bit abort, output bit alu);
    exp_t e;
    logic [3:0] op;
    bit ill;
    op  = ins[15:12];
    alu = (op == 4'h1) || (op == 4'h2) || (op == 4'h3);
    ill = !(alu || op == 4'h0 || op == 4'hF);
    for (int i = 0; i <= w; i++) begin
      e = quiet(); e.req = 1'b1; e.addr = m_pc;
      if (i < w) push(1'b0, rbit(), 1'b0, 16'($urandom), e, (i == 0) ? tf : 0, 1'b0);
      else       push(1'b0, rbit(), 1'b1, ins, e, (i == 0) ? tf : 0, 1'b0);
    end
    m_pc = m_pc + 8'd1;
    e = quiet(); e.illegal = ill;
    push(1'b0, rbit(), rbit(), 16'($urandom), e, td, 1'b0);
    m_f = ref_fields(ins);
    if (alu) begin
      e = quiet(); e.gate = 1'b1;
      push(1'b0, rbit(), rbit(), 16'($urandom), e, te, abort);
      if (!abort) begin
        e = quiet(); e.ldreg = 1'b1;
        push(1'b0, wb_run, rbit(), 16'($urandom), e, tw, 1'b0);
      end
    end
  endtask

  task automatic gen_halted(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = quiet(); e.halted = 1'b1;
      push(1'b0, rbit(), rbit(), 16'($urandom), e, (i == 0) ? T_HALT : 0, 1'b0);
    end
  endtask

  task automatic build_trace();
    bit alu;
    int sel, w;
    logic wbr;
    logic [15:0] ins;
    gen_reset(2);
    gen_idle(10);
    gen_instr(16'h1283, 0, 1'b1, T_FIRST, 0, T_ADD_EXEC, T_ADD_WB, 1'b0, alu);
    gen_instr(16'h2A5C, 0, 1'b1, T_NEXT, 0, T_ADDI, 0, 1'b0, alu);
    gen_instr(16'h3C7F, 3, 1'b0, 0, 0, T_ADDA, 0, 1'b0, alu);
    gen_idle(2);
    gen_instr(16'h7000, 1, 1'b1, 0, T_ILL, 0, 0, 1'b0, alu);
    gen_instr(16'h0000, 0, 1'b1, 0, 0, 0, 0, 1'b0, alu);
    gen_instr(16'hF000, 0, 1'b1, 0, 0, 0, 0, 1'b0, alu);
    gen_halted(8);
    gen_reset(1);
    gen_idle(1);
    gen_instr(16'h1ABC, 0, 1'b1, 0, 0, 0, 0, 1'b1, alu);
    gen_reset(2);
    gen_idle(0);
    for (int k = 0; k < 150; k++) begin
      sel = int'($urandom_range(0, 99));
      ins = 16'($urandom);
      if (sel < 25)      ins[15:12] = 4'h1;
      else if (sel < 45) ins[15:12] = 4'h2;
      else if (sel < 65) ins[15:12] = 4'h3;
      else if (sel < 78) ins[15:12] = 4'h0;
      else if (sel < 94) ins[15:12] = 4'($urandom_range(4, 14));
      else               ins[15:12] = 4'hF;
      w   = rbit() ? 0 : int'($urandom_range(0, 3));
      wbr = ($urandom_range(0, 3) != 0);
      gen_instr(ins, w, wbr, (k == 0) ? T_FIRST : 0, 0, 0, 0, 1'b0, alu);
      if (ins[15:12] == 4'hF) begin
        gen_halted(int'($urandom_range(2, 5)));
        gen_reset(1);
        gen_idle(int'($urandom_range(0, 3)));
      end else if (alu && !wbr) begin
        gen_idle(int'($urandom_range(0, 3)));
      end
    end
  endtask

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input cyc_t r);
    @(posedge CLK);
    #1;
    RST        = r.rst;
    RUN        = r.run;
    IMEM_ACK   = r.ack;
    IMEM_RDATA = r.rdata;
  endtask

  task automatic checkOutput(input cyc_t r);
    cmp("IMEM_REQ", 16'(IMEM_REQ), 16'(r.e.req));
    if (r.e.req) cmp("IMEM_ADDR", 16'(IMEM_ADDR), 16'(r.e.addr));
    cmp("GATEALU",   16'(GATEALU),   16'(r.e.gate));
    cmp("LDREG",     16'(LDREG),     16'(r.e.ldreg));
    cmp("HALTED",    16'(HALTED),    16'(r.e.halted));
    cmp("ILLEGAL",   16'(ILLEGAL),   16'(r.e.illegal));
    cmp("ALUK",      16'(ALUK),      16'(r.e.f.aluk));
    cmp("SR2select", 16'(SR2select), 16'(r.e.f.sr2));
    cmp("REGISTER1", 16'(REGISTER1), 16'(r.e.f.r1));
    cmp("REGISTER2", 16'(REGISTER2), 16'(r.e.f.r2));
    cmp("DR",        16'(DR),        16'(r.e.f.dr));
    cmp("DATA",      16'(DATA),      16'(r.e.f.data));
    cmp("ADDRESS",   16'(ADDRESS),   16'(r.e.f.address));
    // Hand-computed anchors that pin the model itself
    case (r.tag)
      T_RESET: begin
        cmp("rst_req", 16'(IMEM_REQ), 16'd0);   cmp("rst_gate", 16'(GATEALU), 16'd0);
        cmp("rst_ldreg", 16'(LDREG), 16'd0);    cmp("rst_halted", 16'(HALTED), 16'd0);
        cmp("rst_illegal", 16'(ILLEGAL), 16'd0); cmp("rst_aluk", 16'(ALUK), 16'd0);
        cmp("rst_sr2", 16'(SR2select), 16'd0);  cmp("rst_r1", 16'(REGISTER1), 16'd0);
        cmp("rst_r2", 16'(REGISTER2), 16'd0);   cmp("rst_data", 16'(DATA), 16'd0);
        cmp("rst_address", 16'(ADDRESS), 16'd0); cmp("rst_dr", 16'(DR), 16'd0);
      end
      T_FIRST: begin
        cmp("first_req", 16'(IMEM_REQ), 16'd1);
        cmp("first_addr", 16'(IMEM_ADDR), 16'h00FF);
      end
      T_ADD_EXEC: begin
        cmp("add_gate", 16'(GATEALU), 16'd1); cmp("add_ldreg_low", 16'(LDREG), 16'd0);
        cmp("add_r1", 16'(REGISTER1), 16'd2); cmp("add_r2", 16'(REGISTER2), 16'd3);
        cmp("add_dr", 16'(DR), 16'd1);        cmp("add_sr2", 16'(SR2select), 16'd0);
        cmp("add_aluk", 16'(ALUK), 16'd3);
      end
      T_ADD_WB: begin
        cmp("wb_ldreg", 16'(LDREG), 16'd1); cmp("wb_gate_low", 16'(GATEALU), 16'd0);
        cmp("wb_dr", 16'(DR), 16'd1);
      end
      T_NEXT: begin
        cmp("next_req", 16'(IMEM_REQ), 16'd1);
        cmp("next_addr_wrap", 16'(IMEM_ADDR), 16'h0000);
      end
      T_ADDI: begin
        cmp("addi_r1", 16'(REGISTER1), 16'd5);  cmp("addi_dr", 16'(DR), 16'd5);
        cmp("addi_data", 16'(DATA), 16'h005C);  cmp("addi_sr2", 16'(SR2select), 16'd1);
        cmp("addi_address", 16'(ADDRESS), 16'd0); cmp("addi_r2", 16'(REGISTER2), 16'd0);
      end
      T_ADDA: begin
        cmp("adda_r1", 16'(REGISTER1), 16'd6);  cmp("adda_dr", 16'(DR), 16'd6);
        cmp("adda_address", 16'(ADDRESS), 16'h007F); cmp("adda_sr2", 16'(SR2select), 16'd2);
        cmp("adda_data", 16'(DATA), 16'd0);
      end
      T_ILL: begin
        cmp("ill_pulse", 16'(ILLEGAL), 16'd1); cmp("ill_gate", 16'(GATEALU), 16'd0);
      end
      T_HALT: begin
        cmp("halt_flag", 16'(HALTED), 16'd1); cmp("halt_req", 16'(IMEM_REQ), 16'd0);
      end
      default: ;
    endcase
  endtask

  initial begin
    cyc_t r;
    RST = 1'b1; RUN = 1'b0; IMEM_ACK = 1'b0; IMEM_RDATA = 16'h0000;
    build_trace();
    $display("[TB] replaying %0d cycles", trace.size());
    while (trace.size() > 0) begin
      r = trace.pop_front();
      applyStimulus(r);
      @(negedge CLK);
      checkOutput(r);
      // Reset asserted partway through EXECUTE must drop the gate at once
      if (r.mid_rst) begin
        #1 RST = 1'b1;
        #1;
        cmp("midrst_gate", 16'(GATEALU), 16'd0);
        cmp("midrst_req", 16'(IMEM_REQ), 16'd0);
      end
      cyc++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
